alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_op  in  5  ALU opcode, team ALU encoding: ADD 00000, SUB 00010, SLT 00100, SLTU 00101, AND 01001, OR 01010, XOR 01011, SLL 01110, SRL 01111, SRA 10000, SRC0 10001, SRC1 10010.
REQ-006 req0_src0 / req0_src1  in  32 each  operands of requester 0.
REQ-007 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_op, req1_src0, req1_src1, req1_ready  same as REQ-004..007, requester 1.
REQ-009 alu_op  out  5; alu_src0 / alu_src1  out  32 each  drive the shared ALU.
REQ-010 alu_res  in  32  combinational result from the shared ALU.
REQ-011 rsp_valid  out  1  response register holds a result.
REQ-012 rsp_id  out  1  requester owning the response (0 or 1).
REQ-013 rsp_res  out  32  captured result.
REQ-014 rsp_ready  in  1  consumer takes the response this cycle.

Function
REQ-015 Transfer rule: a request transfers when reqN_valid and reqN_ready are both high on a rising edge; a response transfers when rsp_valid and rsp_ready are both high.
REQ-016 Accept window: grant is possible only when rsp_valid is low, or rsp_valid and rsp_ready are both high in the same cycle (full throughput, one op per cycle).
REQ-017 Grant: at most one of req0_ready/req1_ready is high per cycle; readiness is combinational from valids, accept window and priority state; ready never asserts without the matching valid.
REQ-018 Single valid requester inside the accept window: that requester is granted.
REQ-019 Both valid: the requester not granted last (last_grant pointer) is granted.
REQ-020 last_grant updates to the granted id on every grant; it holds when nothing is granted.
REQ-021 ALU drive: alu_op/alu_src0/alu_src1 mirror the granted requester; with no grant they mirror requester 0 (value irrelevant).
REQ-022 Latency: an operation granted in cycle N appears on rsp_valid/rsp_id/rsp_res in cycle N+1 (alu_res captured on the grant edge).
REQ-023 Back-pressure: while rsp_valid=1 and rsp_ready=0, rsp_id/rsp_res hold stable and no grant occurs.
REQ-024 Drain: rsp_ready high with no new grant clears rsp_valid next cycle; rsp_res/rsp_id hold their last values.
REQ-025 Undefined opcodes pass through; the captured result is whatever alu_res presents (0 from the team ALU).
REQ-026 Per-requester 16-bit grant counters gnt_cnt0/gnt_cnt1 (internal, debug-visible) increment on each grant and wrap from 0xFFFF to 0x0000.

Reset
REQ-027 Asserting rst forces immediately: rsp_valid=0, rsp_id=0, rsp_res=0, last_grant=1 (requester 0 wins the first tie), gnt_cnt0=gnt_cnt1=0.
REQ-028 Reset mid-operation discards any held response; no req*_ready asserts while rst is high.

Configuration
REQ-029 Macro ALU_ARB_ROUND_ROBIN_EN defined: tie resolution per REQ-019/020.
REQ-030 Macro undefined: fixed priority, requester 0 always wins ties; last_grant is not implemented; all other behaviour identical.

Verification
REQ-031 Reset release, req0 ADD 3+4 alone, rsp_ready=1 -> req0_ready=1 cycle N; cycle N+1 rsp_valid=1, rsp_id=0, rsp_res=7.
REQ-032 Both valid for 4 cycles (req0 SUB 10-3, req1 SLTU 1,2), rsp_ready=1, macro on -> grants 0,1,0,1; responses 7,1,7,1 with ids 0,1,0,1.
REQ-033 Same stimulus, macro off -> grants 0,0,0,0; req1_ready never high.
REQ-034 req1 SRA 0x80000000>>4 granted, rsp_ready=0 for 3 cycles -> rsp_res=0xF8000000 held, req*_ready=0 throughout; rsp_ready=1 -> transfer and new grant same cycle.
REQ-035 rst pulsed while rsp_valid=1 -> rsp_valid=0, rsp_res=0 asynchronously; first tie afterwards grants requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational ALU, with a one-entry response register.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise requester 0 always wins ties.
module alu_share_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [4:0]        req0_op,
  input  logic [DATA_W-1:0] req0_src0,
  input  logic [DATA_W-1:0] req0_src1,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_op,
  input  logic [DATA_W-1:0] req1_src0,
  input  logic [DATA_W-1:0] req1_src1,
  output logic              req1_ready,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_src0,
  output logic [DATA_W-1:0] alu_src1,
  input  logic [DATA_W-1:0] alu_res,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_res,
  input  logic              rsp_ready
);

  logic        accept;
  logic        prefer1;
  logic        gnt0;
  logic        gnt1;
  logic        any_gnt;
  logic [15:0] gnt_cnt0;
  logic [15:0] gnt_cnt1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie, the requester that did not win last time goes first.
  assign prefer1 = ~last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (any_gnt) begin
      last_grant <= gnt1;
    end
  end
`else
  assign prefer1 = 1'b0;
`endif

  // The response slot can be refilled when empty or when it drains this same cycle.
  assign accept = ~rst & (~rsp_valid | rsp_ready);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (accept) begin
      if (req0_valid && req1_valid) begin
        gnt0 = ~prefer1;
        gnt1 = prefer1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign any_gnt    = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    alu_op   = req0_op;
    alu_src0 = req0_src0;
    alu_src1 = req0_src1;
    if (gnt1) begin
      alu_op   = req1_op;
      alu_src0 = req1_src0;
      alu_src1 = req1_src1;
    end
  end

  // The ALU result is captured on the grant edge; id and result hold after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
    end else if (any_gnt) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt1;
      rsp_res   <= alu_res;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt1) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter; the bench also plays the shared ALU.
// Honours ALU_ARB_ROUND_ROBIN_EN so expectations track the build configuration.
module tb_alu_share_arbiter;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_SLT  = 5'b00100;
  localparam logic [4:0] OP_SLTU = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_XOR  = 5'b01011;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_SRL  = 5'b01111;
  localparam logic [4:0] OP_SRA  = 5'b10000;
  localparam logic [4:0] OP_SRC0 = 5'b10001;
  localparam logic [4:0] OP_SRC1 = 5'b10010;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_src0, req0_src1, req1_src0, req1_src1;
  logic        req0_ready, req1_ready;
  logic [4:0]  alu_op;
  logic [31:0] alu_src0, alu_src1, alu_res;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_res;
  logic        rsp_ready;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the response slot, tie pointer and grant tallies.
  bit          m_valid;
  bit          m_id;
  logic [31:0] m_res;
  bit          m_last;
  int          m_cnt0, m_cnt1;
  bit          e0, e1;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      OP_SRC0: return a;
      OP_SRC1: return b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res = alu_ref(alu_op, alu_src0, alu_src1);

  alu_share_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_src0(req0_src0), .req0_src1(req0_src1), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_src0(req1_src0), .req1_src1(req1_src1), .req1_ready(req1_ready),
    .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_ready(rsp_ready)
  );

  task automatic set_req(input bit v0, input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input bit v1, input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input bit rr);
    req0_valid = v0; req0_op = op0; req0_src0 = a0; req0_src1 = b0;
    req1_valid = v1; req1_op = op1; req1_src0 = a1; req1_src1 = b1;
    rsp_ready  = rr;
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_res = 32'd0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Expected grant from the rules: slot free or draining, lone requester wins, ties by pointer or priority.
  task automatic predict();
    bit acc;
    acc = !m_valid || rsp_ready;
    e0 = 0; e1 = 0;
    if (acc) begin
      if (req0_valid && req1_valid) begin
        if (RR_MODE && !m_last) e1 = 1; else e0 = 1;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
  endtask

  task automatic commit();
    if (e0 || e1) begin
      m_valid = 1;
      m_id    = e1;
      m_res   = e1 ? alu_ref(req1_op, req1_src0, req1_src1) : alu_ref(req0_op, req0_src0, req0_src1);
      m_last  = e1;
      if (e0) m_cnt0 = (m_cnt0 + 1) % 65536;
      if (e1) m_cnt1 = (m_cnt1 + 1) % 65536;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    set_req(1, OP_ADD, 32'd1, 32'd2, 1, OP_ADD, 32'd3, 32'd4, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00)
      $display("[TB] FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    if ({req0_ready, req1_ready} !== 2'b00) miscompares++;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_res} !== 34'd0) begin
      $display("[TB] FAIL reset_rsp: got v=%b id=%b res=%h want all zero", rsp_valid, rsp_id, rsp_res);
      miscompares++;
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_add();
    set_req(1, OP_ADD, 32'd3, 32'd4, 0, OP_SUB, 32'd9, 32'd9, 1);
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("[TB] FAIL add_grant: got %b want 10", {req0_ready, req1_ready});
      miscompares++;
    end
    predict();
    @(posedge clk);
    commit();
    #1;
    set_req(0, OP_ADD, 32'd0, 32'd0, 0, OP_ADD, 32'd0, 32'd0, 1);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b0, 32'd7}) begin
      $display("[TB] FAIL add_rsp: got v=%b id=%b res=%0d want v=1 id=0 res=7", rsp_valid, rsp_id, rsp_res);
      miscompares++;
    end
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic test_tie();
    bit          want1;
    logic [31:0] want_res;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1, OP_SUB, 32'd10, 32'd3, 1, OP_SLTU, 32'd1, 32'd2, 1);
      want1 = RR_MODE ? bit'(i % 2) : 1'b0;
      want_res = want1 ? 32'd1 : 32'd7;
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready} !== {~want1, want1}) begin
        $display("[TB] FAIL tie_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready}, {~want1, want1});
        miscompares++;
      end
      predict();
      @(posedge clk);
      commit();
      #1;
      vectors++;
      if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, want1, want_res}) begin
        $display("[TB] FAIL tie_rsp[%0d]: got v=%b id=%b res=%0d want v=1 id=%b res=%0d",
                 i, rsp_valid, rsp_id, rsp_res, want1, want_res);
        miscompares++;
      end
    end
    set_req(0, OP_ADD, 32'd0, 32'd0, 0, OP_ADD, 32'd0, 32'd0, 1);
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic test_backpressure();
    set_req(0, OP_ADD, 32'd0, 32'd0, 1, OP_SRA, 32'h8000_0000, 32'd4, 1);
    predict();
    @(posedge clk);
    commit();
    #1;
    for (int i = 0; i < 3; i++) begin
      set_req(1, OP_ADD, 32'd5, 32'd6, 1, OP_XOR, 32'hFF, 32'h0F, 0);
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_res} !== {4'b0011, 32'hF800_0000}) begin
        $display("[TB] FAIL bp_hold[%0d]: got rdy=%b v=%b id=%b res=%h want rdy=00 v=1 id=1 res=f8000000",
                 i, {req0_ready, req1_ready}, rsp_valid, rsp_id, rsp_res);
        miscompares++;
      end
      predict();
      @(posedge clk);
      commit();
      #1;
    end
    rsp_ready = 1'b1;
    predict();
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== {e0, e1} || !(req0_ready || req1_ready)) begin
      $display("[TB] FAIL bp_release: got %b want %b", {req0_ready, req1_ready}, {e0, e1});
      miscompares++;
    end
    @(posedge clk);
    commit();
    #1;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_res} !== {m_valid, m_id, m_res}) begin
      $display("[TB] FAIL bp_next_rsp: got v=%b id=%b res=%h want v=%b id=%b res=%h",
               rsp_valid, rsp_id, rsp_res, m_valid, m_id, m_res);
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    set_req(1, OP_OR, 32'hA5A5_0000, 32'h0000_5A5A, 0, OP_ADD, 32'd0, 32'd0, 1);
    predict();
    @(posedge clk);
    commit();
    #1;
    set_req(1, OP_ADD, 32'd1, 32'd1, 1, OP_ADD, 32'd2, 32'd2, 0);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({rsp_valid, rsp_res, req0_ready, req1_ready} !== 35'd0) begin
      $display("[TB] FAIL async_rst: got v=%b res=%h rdy=%b want v=0 res=0 rdy=00",
               rsp_valid, rsp_res, {req0_ready, req1_ready});
      miscompares++;
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("[TB] FAIL post_rst_tie: got %b want 10", {req0_ready, req1_ready});
      miscompares++;
    end
    predict();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic test_random();
    logic [4:0] ops [12] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR,
                             OP_SLL, OP_SRL, OP_SRA, OP_SRC0, OP_SRC1};
    logic [4:0] op0, op1;
    for (int i = 0; i < 400; i++) begin
      op0 = ($urandom_range(9) == 0) ? 5'($urandom) : ops[$urandom_range(11)];
      op1 = ($urandom_range(9) == 0) ? 5'($urandom) : ops[$urandom_range(11)];
      set_req($urandom_range(2) != 0, op0, $urandom, $urandom,
              $urandom_range(2) != 0, op1, $urandom, $urandom, $urandom_range(3) != 0);
      predict();
      @(negedge clk);
      vectors++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        $display("[TB] FAIL rnd_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready}, {e0, e1});
        miscompares++;
      end
      vectors++;
      if ({alu_op, alu_src0, alu_src1} !== (e1 ? {req1_op, req1_src0, req1_src1} : {req0_op, req0_src0, req0_src1})) begin
        $display("[TB] FAIL rnd_alu_drive[%0d]: got op=%h a=%h b=%h gnt1=%b", i, alu_op, alu_src0, alu_src1, e1);
        miscompares++;
      end
      @(posedge clk);
      commit();
      #1;
      vectors++;
      if ({rsp_valid, rsp_id, rsp_res} !== {m_valid, m_id, m_res}) begin
        $display("[TB] FAIL rnd_rsp[%0d]: got v=%b id=%b res=%h want v=%b id=%b res=%h",
                 i, rsp_valid, rsp_id, rsp_res, m_valid, m_id, m_res);
        miscompares++;
      end
    end
    vectors++;
    if (dut.gnt_cnt0 !== 16'(m_cnt0) || dut.gnt_cnt1 !== 16'(m_cnt1)) begin
      $display("[TB] FAIL gnt_counts: got %0d/%0d want %0d/%0d", dut.gnt_cnt0, dut.gnt_cnt1, m_cnt0, m_cnt1);
      miscompares++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_add();
    test_tie();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
